// File: rtl/fir_out_checker.sv
// Self-checking receiver for an 11-tap FIR output stream: rebuilds the bit-exact
// golden result per input sample, queues it, and compares it against each output sample.
module fir_out_checker #(
  parameter int unsigned NB    = 11,
  parameter int unsigned SHIFT = 10,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NSAMP = 16
) (
  input  logic          CLK,
  input  logic          RST_n,
  input  logic [NB-1:0] DIN,
  input  logic          VIN,
  input  logic [NB-1:0] B0,
  input  logic [NB-1:0] B1,
  input  logic [NB-1:0] B2,
  input  logic [NB-1:0] B3,
  input  logic [NB-1:0] B4,
  input  logic [NB-1:0] B5,
  input  logic [NB-1:0] B6,
  input  logic [NB-1:0] B7,
  input  logic [NB-1:0] B8,
  input  logic [NB-1:0] B9,
  input  logic [NB-1:0] B10,
  input  logic [NB-1:0] DOUT,
  input  logic          VOUT,
  output logic [15:0]   SMP_CNT,
  output logic [15:0]   ERR_CNT,
  output logic          MISMATCH,
  output logic          UNDERFLOW,
  output logic          OVERFLOW,
  output logic          DONE
);

  localparam int unsigned NTAP = 11;
  localparam int unsigned PW   = 2 * NB;
  localparam int unsigned ACCW = 2 * NB + 4;
  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = AW + 1;

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_DONE = 1'b1;

  // Only x[0..9] are stored: x[10] after the shift is the old x[9], read straight from here.
  logic signed [NB-1:0]   r_x [NTAP-1];
  logic signed [NB-1:0]   w_b [NTAP];
  logic signed [NB-1:0]   w_tap [NTAP];
  logic signed [PW-1:0]   w_prod [NTAP];
  logic signed [ACCW-1:0] w_acc;
  logic [NB-1:0]          w_exp;

  logic [NB-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_neq;

  logic [0:0]  r_state;
  logic [0:0]  w_state_nxt;
  logic [15:0] r_smp_cnt;
  logic [15:0] r_err_cnt;
  logic        r_mismatch;
  logic        r_underflow;
  logic        r_overflow;
  logic [15:0] w_smp_nxt;
  logic [15:0] w_err_nxt;
  logic        w_mis_nxt;
  logic        w_uf_nxt;
  logic        w_of_nxt;

  assign w_b[0]  = B0;
  assign w_b[1]  = B1;
  assign w_b[2]  = B2;
  assign w_b[3]  = B3;
  assign w_b[4]  = B4;
  assign w_b[5]  = B5;
  assign w_b[6]  = B6;
  assign w_b[7]  = B7;
  assign w_b[8]  = B8;
  assign w_b[9]  = B9;
  assign w_b[10] = B10;

  // Golden value for the line as it will look after this sample shifts in.
  always_comb begin
    w_acc    = '0;
    w_tap[0] = DIN;
    for (int k = 1; k < NTAP; k++) begin
      w_tap[k] = r_x[k-1];
    end
    for (int k = 0; k < NTAP; k++) begin
      w_prod[k] = PW'(w_tap[k]) * PW'(w_b[k]);
      w_acc     = w_acc + ACCW'(w_prod[k]);
    end
    w_exp = NB'(w_acc >>> SHIFT);
  end

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = VOUT & ~w_empty;
  assign w_push  = VIN & (~w_full | w_pop);
  assign w_neq   = w_pop & (r_mem[r_rd_ptr] != DOUT);

  // Storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge CLK) begin
    if (RST_n && w_push) begin
      r_mem[r_wr_ptr] <= w_exp;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      for (int k = 0; k < NTAP - 1; k++) begin
        r_x[k] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (VIN) begin
        r_x[0] <= DIN;
        for (int k = 1; k < NTAP - 1; k++) begin
          r_x[k] <= r_x[k-1];
        end
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Next state and next outputs; in DONE everything visible freezes.
  always_comb begin
    w_state_nxt = r_state;
    w_smp_nxt   = r_smp_cnt;
    w_err_nxt   = r_err_cnt;
    w_mis_nxt   = 1'b0;
    w_uf_nxt    = r_underflow;
    w_of_nxt    = r_overflow;
    case (r_state)
      S_RUN: begin
        if (w_pop) begin
          if (r_smp_cnt != 16'hFFFF) begin
            w_smp_nxt = r_smp_cnt + 16'd1;
          end
          if (w_neq) begin
            w_mis_nxt = 1'b1;
            if (r_err_cnt != 16'hFFFF) begin
              w_err_nxt = r_err_cnt + 16'd1;
            end
          end
          if (w_smp_nxt == 16'(NSAMP)) begin
            w_state_nxt = S_DONE;
          end
        end
        if (VOUT && w_empty) begin
          w_uf_nxt = 1'b1;
        end
        if (VIN && w_full && !w_pop) begin
          w_of_nxt = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_DONE;
      end
      default: begin
        w_state_nxt = S_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      r_state     <= S_RUN;
      r_smp_cnt   <= '0;
      r_err_cnt   <= '0;
      r_mismatch  <= 1'b0;
      r_underflow <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_smp_cnt   <= w_smp_nxt;
      r_err_cnt   <= w_err_nxt;
      r_mismatch  <= w_mis_nxt;
      r_underflow <= w_uf_nxt;
      r_overflow  <= w_of_nxt;
    end
  end

  assign SMP_CNT   = r_smp_cnt;
  assign ERR_CNT   = r_err_cnt;
  assign MISMATCH  = r_mismatch;
  assign UNDERFLOW = r_underflow;
  assign OVERFLOW  = r_overflow;
  assign DONE      = (r_state == S_DONE);

endmodule

// File: tb/tb_fir_out_checker.sv
// Directed bench for fir_out_checker: a vector table for single-cycle behaviour plus
// hand-written sequences for overflow, DONE/reset and multi-tap arithmetic.
module tb_fir_out_checker;

  localparam int NB    = 11;
  localparam int DEPTH = 8;
  localparam int NSAMP = 16;

  logic          CLK = 1'b0;
  logic          RST_n;
  logic [NB-1:0] DIN;
  logic          VIN;
  logic [NB-1:0] B [11];
  logic [NB-1:0] DOUT;
  logic          VOUT;
  logic [15:0]   SMP_CNT;
  logic [15:0]   ERR_CNT;
  logic          MISMATCH;
  logic          UNDERFLOW;
  logic          OVERFLOW;
  logic          DONE;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic rst_n;
    logic vin;
    int   din;
    logic vout;
    int   dout;
    int   smp;
    int   err;
    int   mis;
    int   uf;
    int   of;
    int   dn;
  } vec_t;

  vec_t tbl[$];

  // Expected outputs for the two multi-tap sequences, worked by hand.
  int ms_exp [11] = '{9, 18, 27, 36, 45, 54, 63, 72, 81, 90, 99};
  int tw_din [5]  = '{-3, 200, 400, 0, 0};
  int tw_exp [5]  = '{0, -2, 99, 250, 100};

  always #5 CLK = ~CLK;

  fir_out_checker #(.NB(NB), .SHIFT(10), .DEPTH(DEPTH), .NSAMP(NSAMP)) dut (
    .CLK(CLK), .RST_n(RST_n), .DIN(DIN), .VIN(VIN),
    .B0(B[0]), .B1(B[1]), .B2(B[2]), .B3(B[3]), .B4(B[4]), .B5(B[5]),
    .B6(B[6]), .B7(B[7]), .B8(B[8]), .B9(B[9]), .B10(B[10]),
    .DOUT(DOUT), .VOUT(VOUT),
    .SMP_CNT(SMP_CNT), .ERR_CNT(ERR_CNT), .MISMATCH(MISMATCH),
    .UNDERFLOW(UNDERFLOW), .OVERFLOW(OVERFLOW), .DONE(DONE)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int smp, input int err, input int mis,
                         input int uf, input int of, input int dn);
    chk({tag, " SMP_CNT"},   int'(SMP_CNT),   smp);
    chk({tag, " ERR_CNT"},   int'(ERR_CNT),   err);
    chk({tag, " MISMATCH"},  int'(MISMATCH),  mis);
    chk({tag, " UNDERFLOW"}, int'(UNDERFLOW), uf);
    chk({tag, " OVERFLOW"},  int'(OVERFLOW),  of);
    chk({tag, " DONE"},      int'(DONE),      dn);
  endtask

  // Drive one cycle of inputs, clock it, and leave time 1 unit past the edge.
  task automatic cyc(input logic rst, input logic vin, input int din,
                     input logic vout, input int dout);
    RST_n = rst;
    VIN   = vin;
    DIN   = NB'(din);
    VOUT  = vout;
    DOUT  = NB'(dout);
    @(posedge CLK);
    #1;
  endtask

  task automatic add(input logic r, input logic vi, input int di, input logic vo, input int dq,
                     input int s, input int e, input int m, input int u, input int o, input int d);
    vec_t v;
    v.rst_n = r; v.vin = vi; v.din = di; v.vout = vo; v.dout = dq;
    v.smp = s; v.err = e; v.mis = m; v.uf = u; v.of = o; v.dn = d;
    tbl.push_back(v);
  endtask

  task automatic set_identity();
    for (int k = 0; k < 11; k++) B[k] = NB'(0);
    // 1024 does not fit a signed 11-bit coefficient; it lands as -1024, so the echo is -DIN.
    B[0] = NB'(1024);
  endtask

  initial begin
    RST_n = 1'b0; VIN = 1'b0; VOUT = 1'b0; DIN = '0; DOUT = '0;
    set_identity();

    // Identity stream, latency 3.
    add(0, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0);
    add(1, 1, 5,     0, 0,     0, 0, 0, 0, 0, 0);
    add(1, 1, -3,    0, 0,     0, 0, 0, 0, 0, 0);
    add(1, 1, 1023,  0, 0,     0, 0, 0, 0, 0, 0);
    add(1, 1, -1024, 1, -5,    1, 0, 0, 0, 0, 0);
    add(1, 0, 0,     1, 3,     2, 0, 0, 0, 0, 0);
    add(1, 0, 0,     1, -1023, 3, 0, 0, 0, 0, 0);
    add(1, 0, 0,     1, -1024, 4, 0, 0, 0, 0, 0);
    add(1, 0, 0,     0, 0,     4, 0, 0, 0, 0, 0);
    // Third output corrupted: -7 where -6 is due.
    add(0, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0);
    add(1, 1, 4,     0, 0,     0, 0, 0, 0, 0, 0);
    add(1, 1, 5,     0, 0,     0, 0, 0, 0, 0, 0);
    add(1, 1, 6,     0, 0,     0, 0, 0, 0, 0, 0);
    add(1, 1, 8,     1, -4,    1, 0, 0, 0, 0, 0);
    add(1, 0, 0,     1, -5,    2, 0, 0, 0, 0, 0);
    add(1, 0, 0,     1, -7,    3, 1, 1, 0, 0, 0);
    add(1, 0, 0,     1, -8,    4, 1, 0, 0, 0, 0);
    add(1, 0, 0,     0, 0,     4, 1, 0, 0, 0, 0);
    // Underflow without input, sticky, cleared by reset.
    add(0, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0);
    add(1, 0, 0,     1, 0,     0, 0, 0, 1, 0, 0);
    add(1, 0, 0,     0, 0,     0, 0, 0, 1, 0, 0);
    add(0, 0, 0,     0, 0,     0, 0, 0, 0, 0, 0);
    // VOUT on the same edge as the first VIN: underflow, value stays queued.
    add(1, 1, 9,     1, -9,    0, 0, 0, 1, 0, 0);
    add(1, 0, 0,     1, -9,    1, 0, 0, 1, 0, 0);
    // Reset wins over VIN/VOUT: nothing is pushed during it.
    add(0, 1, 3,     1, -3,    0, 0, 0, 0, 0, 0);
    add(1, 0, 0,     1, -3,    0, 0, 0, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst_n, tbl[i].vin, tbl[i].din, tbl[i].vout, tbl[i].dout);
      chk_all($sformatf("row%0d", i), tbl[i].smp, tbl[i].err, tbl[i].mis,
              tbl[i].uf, tbl[i].of, tbl[i].dn);
    end

    // Overflow: DEPTH+1 inputs with no output, then push+pop while full.
    cyc(0, 0, 0, 0, 0);
    for (int k = 1; k <= DEPTH + 1; k++) begin
      cyc(1, 1, k, 0, 0);
      chk($sformatf("ovf push%0d OVERFLOW", k), int'(OVERFLOW), (k == DEPTH + 1) ? 1 : 0);
    end
    cyc(1, 1, 20, 1, -1);
    chk_all("ovf full push+pop", 1, 0, 0, 0, 1, 0);
    for (int k = 2; k <= DEPTH; k++) cyc(1, 0, 0, 1, -k);
    cyc(1, 0, 0, 1, -20);
    chk_all("ovf drained", DEPTH + 1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    chk_all("ovf past empty", DEPTH + 1, 0, 0, 1, 1, 0);

    // DONE after NSAMP compares, then freeze, then reset discards queued values.
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i <= NSAMP; i++) begin
      cyc(1, (i < NSAMP), i + 1, (i > 0), -i);
      chk($sformatf("done i%0d SMP_CNT", i), int'(SMP_CNT), i);
      chk($sformatf("done i%0d DONE", i), int'(DONE), (i == NSAMP) ? 1 : 0);
    end
    cyc(1, 1, 17, 0, 0);
    cyc(1, 1, 50, 1, 0);
    chk_all("done frozen bad pop", NSAMP, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 1, 60, 0, 0);
    chk_all("done frozen", NSAMP, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk_all("done reset", 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 33, 0, 0);
    cyc(1, 0, 0, 1, -33);
    chk_all("after reset compare", 1, 0, 0, 0, 0, 0);

    // Tap weighting B1=0.5, B2=0.25 with a negative sample and floor rounding.
    for (int k = 0; k < 11; k++) B[k] = NB'(0);
    B[1] = NB'(512);
    B[2] = NB'(256);
    cyc(0, 0, 0, 0, 0);
    for (int n = 0; n <= 5; n++) begin
      if (n == 0)      cyc(1, 1, tw_din[0], 0, 0);
      else if (n < 5)  cyc(1, 1, tw_din[n], 1, tw_exp[n-1]);
      else             cyc(1, 0, 0, 1, tw_exp[4]);
      chk($sformatf("taps n%0d ERR_CNT", n), int'(ERR_CNT), 0);
    end
    chk_all("taps end", 5, 0, 0, 0, 0, 0);

    // Moving sum over all 11 taps, DIN=100, coefficients 93.
    for (int k = 0; k < 11; k++) B[k] = NB'(93);
    cyc(0, 0, 0, 0, 0);
    for (int n = 0; n <= 11; n++) begin
      if (n == 0)      cyc(1, 1, 100, 0, 0);
      else if (n < 11) cyc(1, 1, 100, 1, ms_exp[n-1]);
      else             cyc(1, 0, 0, 1, ms_exp[10]);
      chk($sformatf("msum n%0d MISMATCH", n), int'(MISMATCH), 0);
    end
    chk_all("msum end", 11, 0, 0, 0, 0, 0);
    // A wrong final value must register once the line is fully loaded.
    cyc(1, 1, 100, 0, 0);
    cyc(1, 0, 0, 1, 98);
    chk_all("msum wrong", 12, 1, 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
